// File: rtl/inst_trace_buffer_pkg.sv
// inst_trace_buffer_pkg
// Purpose: shared definitions for the instruction trace buffer and its
//          mnemonic decoder: MIPS32 opcode/funct/rt/rs field constants,
//          the ERET encoding, FSM state encodings, the trace entry layout
//          and the minimum mnemonic text width.
// Ports:   none (package).
package inst_trace_buffer_pkg;

  // Mnemonic text width; every mnemonic is at most six characters.
  localparam int ASCII_W_MIN = 48;

  // FSM state encodings, also driven straight onto the state output.
  localparam logic [1:0] ST_ARMED  = 2'b00;
  localparam logic [1:0] ST_POST   = 2'b01;
  localparam logic [1:0] ST_FROZEN = 2'b10;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes (instr[5:0]).
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // REGIMM rt codes (instr[20:16]).
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // COP0 rs codes (instr[25:21]).
  localparam logic [4:0] RS_MFC0 = 5'h00;
  localparam logic [4:0] RS_MTC0 = 5'h04;

  localparam logic [31:0] ERET_ENC = 32'h4200_0018;

  // One stored trace record; text is never stored, only decoded on read.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/inst_mnemonic_lut.sv
// inst_mnemonic_lut
// Purpose: combinational MIPS32 integer-subset decoder producing a
//          right-justified, zero-padded 8-bit ASCII mnemonic.
// Ports:   instr [31:0]         in   instruction encoding
//          ascii [ASCII_W-1:0]  out  mnemonic text
module inst_mnemonic_lut
  import inst_trace_buffer_pkg::*;
#(
  parameter int ASCII_W = ASCII_W_MIN
) (
  input  logic [31:0]        instr,
  output logic [ASCII_W-1:0] ascii
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [47:0] txt;
  logic        unused_bits;

  assign op          = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[15:6];

  // NOP and ERET are whole-word matches and win over field decoding;
  // anything not recognised falls back to "N-R". SYSCALL is clipped to
  // six characters so that every mnemonic fits the minimum width.
  always_comb begin
    txt = 48'("N-R");
    if (instr == 32'h0) begin
      txt = 48'("NOP");
    end else if (instr == ERET_ENC) begin
      txt = 48'("ERET");
    end else begin
      case (op)
        OP_SPECIAL: begin
          case (funct)
            FN_SLL:     txt = 48'("SLL");
            FN_SRL:     txt = 48'("SRL");
            FN_SRA:     txt = 48'("SRA");
            FN_SLLV:    txt = 48'("SLLV");
            FN_SRLV:    txt = 48'("SRLV");
            FN_SRAV:    txt = 48'("SRAV");
            FN_JR:      txt = 48'("JR");
            FN_JALR:    txt = 48'("JALR");
            FN_SYSCALL: txt = 48'("SYSCAL");
            FN_BREAK:   txt = 48'("BREAK");
            FN_MFHI:    txt = 48'("MFHI");
            FN_MTHI:    txt = 48'("MTHI");
            FN_MFLO:    txt = 48'("MFLO");
            FN_MTLO:    txt = 48'("MTLO");
            FN_MULT:    txt = 48'("MULT");
            FN_MULTU:   txt = 48'("MULTU");
            FN_DIV:     txt = 48'("DIV");
            FN_DIVU:    txt = 48'("DIVU");
            FN_ADD:     txt = 48'("ADD");
            FN_ADDU:    txt = 48'("ADDU");
            FN_SUB:     txt = 48'("SUB");
            FN_SUBU:    txt = 48'("SUBU");
            FN_AND:     txt = 48'("AND");
            FN_OR:      txt = 48'("OR");
            FN_XOR:     txt = 48'("XOR");
            FN_NOR:     txt = 48'("NOR");
            FN_SLT:     txt = 48'("SLT");
            FN_SLTU:    txt = 48'("SLTU");
            default:    txt = 48'("N-R");
          endcase
        end
        OP_REGIMM: begin
          case (rt)
            RT_BLTZ:   txt = 48'("BLTZ");
            RT_BGEZ:   txt = 48'("BGEZ");
            RT_BLTZAL: txt = 48'("BLTZAL");
            RT_BGEZAL: txt = 48'("BGEZAL");
            default:   txt = 48'("N-R");
          endcase
        end
        OP_COP0: begin
          if (rs == RS_MFC0)      txt = 48'("MFC0");
          else if (rs == RS_MTC0) txt = 48'("MTC0");
          else                    txt = 48'("N-R");
        end
        OP_J:     txt = 48'("J");
        OP_JAL:   txt = 48'("JAL");
        OP_BEQ:   txt = 48'("BEQ");
        OP_BNE:   txt = 48'("BNE");
        OP_BLEZ:  txt = 48'("BLEZ");
        OP_BGTZ:  txt = 48'("BGTZ");
        OP_ADDI:  txt = 48'("ADDI");
        OP_ADDIU: txt = 48'("ADDIU");
        OP_SLTI:  txt = 48'("SLTI");
        OP_SLTIU: txt = 48'("SLTIU");
        OP_ANDI:  txt = 48'("ANDI");
        OP_ORI:   txt = 48'("ORI");
        OP_XORI:  txt = 48'("XORI");
        OP_LUI:   txt = 48'("LUI");
        OP_LB:    txt = 48'("LB");
        OP_LH:    txt = 48'("LH");
        OP_LW:    txt = 48'("LW");
        OP_LBU:   txt = 48'("LBU");
        OP_LHU:   txt = 48'("LHU");
        OP_SB:    txt = 48'("SB");
        OP_SH:    txt = 48'("SH");
        OP_SW:    txt = 48'("SW");
        default:  txt = 48'("N-R");
      endcase
    end
  end

  assign ascii = ASCII_W'(txt);

endmodule

// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer
// Purpose: circular instruction-commit trace with PC-match trigger. Records
//          commits while ARMED, keeps TRIG_POST more after a trigger, then
//          freezes and lets a consumer drain entries oldest-first, each
//          decoded to an ASCII mnemonic.
// Ports:   clk, resetn (async, active-low)
//          commit_valid/commit_pc/commit_instr  retiring instruction
//          trig_en/trig_pc                      PC-match trigger
//          clr                                  empty buffer, re-arm
//          rd_ready/rd_valid/rd_pc/rd_instr/rd_ascii  readout handshake
//          state, count, ovw_cnt                status
module inst_trace_buffer
  import inst_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ASCII_W   = ASCII_W_MIN,
  parameter int TRIG_POST = 4,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic [31:0]        commit_instr,
  input  logic               trig_en,
  input  logic [31:0]        trig_pc,
  input  logic               clr,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [31:0]        rd_pc,
  output logic [31:0]        rd_instr,
  output logic [ASCII_W-1:0] rd_ascii,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   count,
  output logic [15:0]        ovw_cnt
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] post_cnt;
  logic          capture;
  logic          trigger;
  logic          pop;
  logic          full;

  assign capture  = commit_valid && (state != ST_FROZEN);
  assign trigger  = commit_valid && trig_en && (commit_pc == trig_pc) &&
                    (state == ST_ARMED);
  assign full     = (count == CNT_W'(DEPTH));
  assign rd_valid = (state == ST_FROZEN) && (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_pc    = mem[rd_ptr].pc;
  assign rd_instr = mem[rd_ptr].instr;

  // Storage is deliberately unreset; count=0 keeps stale data invisible.
  // A clr in the same cycle discards the commit.
  always_ff @(posedge clk) begin
    if (resetn && capture && !clr) begin
      mem[wr_ptr] <= '{pc: commit_pc, instr: commit_instr};
    end
  end

  // Control: capture and pop never coincide because capture is blocked in
  // FROZEN and pop only exists in FROZEN. When full, a capture pushes the
  // read pointer along so the oldest entry is the one lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_ARMED;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      ovw_cnt  <= '0;
    end else if (clr) begin
      state    <= ST_ARMED;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      ovw_cnt  <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (full) begin
          rd_ptr <= rd_ptr + AW'(1);
          if (ovw_cnt != 16'hFFFF) ovw_cnt <= ovw_cnt + 16'd1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end

      case (state)
        ST_ARMED: begin
          if (trigger) begin
            post_cnt <= AW'(TRIG_POST);
            state    <= (TRIG_POST == 0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (commit_valid) begin
            post_cnt <= post_cnt - AW'(1);
            if (post_cnt == AW'(1)) state <= ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) state <= ST_ARMED;
          end
        end
        default: state <= ST_ARMED;
      endcase
    end
  end

  inst_mnemonic_lut #(
    .ASCII_W (ASCII_W)
  ) u_lut (
    .instr (rd_instr),
    .ascii (rd_ascii)
  );

endmodule

// File: tb/tb_inst_trace_buffer.sv
// tb_inst_trace_buffer
// Purpose: directed self-checking bench. Two DEPTH=4 instances share clock
//          and reset: index 0 has TRIG_POST=0, index 1 has TRIG_POST=2.
//          Inputs are driven on the falling edge, outputs sampled there.
// Ports:   none (top-level bench).
module tb_inst_trace_buffer;

  logic        clk;
  logic        resetn;
  logic        commit_valid [2];
  logic [31:0] commit_pc    [2];
  logic [31:0] commit_instr [2];
  logic        trig_en      [2];
  logic [31:0] trig_pc      [2];
  logic        clr          [2];
  logic        rd_ready     [2];
  logic        rd_valid     [2];
  logic [31:0] rd_pc        [2];
  logic [31:0] rd_instr     [2];
  logic [47:0] rd_ascii     [2];
  logic [1:0]  state        [2];
  logic [2:0]  count        [2];
  logic [15:0] ovw_cnt      [2];

  int checks;
  int passes;

  localparam logic [63:0] TXT_NOP  = 64'h0000_0000_004E_4F50;
  localparam logic [63:0] TXT_ERET = 64'h0000_0000_4552_4554;
  localparam logic [63:0] TXT_ADDU = 64'h0000_0000_4144_4455;
  localparam logic [63:0] TXT_NR   = 64'h0000_0000_004E_2D52;

  inst_trace_buffer #(.DEPTH(4), .ASCII_W(48), .TRIG_POST(0)) u_dut0 (
    .clk          (clk),
    .resetn       (resetn),
    .commit_valid (commit_valid[0]),
    .commit_pc    (commit_pc[0]),
    .commit_instr (commit_instr[0]),
    .trig_en      (trig_en[0]),
    .trig_pc      (trig_pc[0]),
    .clr          (clr[0]),
    .rd_ready     (rd_ready[0]),
    .rd_valid     (rd_valid[0]),
    .rd_pc        (rd_pc[0]),
    .rd_instr     (rd_instr[0]),
    .rd_ascii     (rd_ascii[0]),
    .state        (state[0]),
    .count        (count[0]),
    .ovw_cnt      (ovw_cnt[0])
  );

  inst_trace_buffer #(.DEPTH(4), .ASCII_W(48), .TRIG_POST(2)) u_dut1 (
    .clk          (clk),
    .resetn       (resetn),
    .commit_valid (commit_valid[1]),
    .commit_pc    (commit_pc[1]),
    .commit_instr (commit_instr[1]),
    .trig_en      (trig_en[1]),
    .trig_pc      (trig_pc[1]),
    .clr          (clr[1]),
    .rd_ready     (rd_ready[1]),
    .rd_valid     (rd_valid[1]),
    .rd_pc        (rd_pc[1]),
    .rd_instr     (rd_instr[1]),
    .rd_ascii     (rd_ascii[1]),
    .state        (state[1]),
    .count        (count[1]),
    .ovw_cnt      (ovw_cnt[1])
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Presents one commit for a single rising edge; call on a falling edge.
  task automatic apply_stimulus(input int d, input logic [31:0] pc,
                                input logic [31:0] instr);
    commit_valid[d] = 1'b1;
    commit_pc[d]    = pc;
    commit_instr[d] = instr;
    @(negedge clk);
    commit_valid[d] = 1'b0;
  endtask

  // Holds rd_ready for a single rising edge; call on a falling edge.
  task automatic pop_one(input int d);
    rd_ready[d] = 1'b1;
    @(negedge clk);
    rd_ready[d] = 1'b0;
  endtask

  // Guards against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    logic [31:0] pcs    [6];
    logic [31:0] instrs [6];
    logic [31:0] exp_pc [4];
    logic [63:0] exp_tx [4];

    checks = 0;
    passes = 0;
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      commit_valid[d] = 1'b0;
      commit_pc[d]    = '0;
      commit_instr[d] = '0;
      trig_en[d]      = 1'b1;
      clr[d]          = 1'b0;
      rd_ready[d]     = 1'b0;
    end
    trig_pc[0] = 32'h114;
    trig_pc[1] = 32'h200;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_output("reset_state", 64'(state[d]), 64'd0);
      check_output("reset_count", 64'(count[d]), 64'd0);
      check_output("reset_rd_valid", 64'(rd_valid[d]), 64'd0);
    end
    resetn = 1'b1;

    // Six commits into a 4-deep buffer; trigger on the last, no post window.
    pcs    = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
    instrs = '{32'h2408_0001, 32'h2409_0002, 32'h0085_1021, 32'h4200_0018,
               32'hFC00_0000, 32'h0000_0000};
    rd_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, pcs[i], instrs[i]);
      if (i == 3) begin
        check_output("fill_count", 64'(count[0]), 64'd4);
        check_output("armed_rd_valid", 64'(rd_valid[0]), 64'd0);
        check_output("armed_ovw", 64'(ovw_cnt[0]), 64'd0);
      end
    end
    rd_ready[0] = 1'b0;
    check_output("trig0_state", 64'(state[0]), 64'd2);
    check_output("trig0_count", 64'(count[0]), 64'd4);
    check_output("trig0_ovw", 64'(ovw_cnt[0]), 64'd2);

    // Commits while frozen are dropped.
    apply_stimulus(0, 32'h118, 32'h0000_0000);
    check_output("frozen_drop_count", 64'(count[0]), 64'd4);
    check_output("frozen_drop_ovw", 64'(ovw_cnt[0]), 64'd2);

    // Readout oldest-first with mnemonic decode.
    exp_pc = '{32'h108, 32'h10C, 32'h110, 32'h114};
    exp_tx = '{TXT_ADDU, TXT_ERET, TXT_NR, TXT_NOP};
    for (int i = 0; i < 4; i++) begin
      check_output("pop_rd_valid", 64'(rd_valid[0]), 64'd1);
      check_output("pop_rd_pc", 64'(rd_pc[0]), 64'(exp_pc[i]));
      check_output("pop_rd_ascii", 64'(rd_ascii[0]), exp_tx[i]);
      pop_one(0);
    end
    check_output("drain_state", 64'(state[0]), 64'd0);
    check_output("drain_rd_valid", 64'(rd_valid[0]), 64'd0);
    check_output("drain_ovw_kept", 64'(ovw_cnt[0]), 64'd2);

    // Post-trigger window of two: 0x200 + two more, the fourth is dropped.
    apply_stimulus(1, 32'h200, 32'h0000_0000);
    check_output("post_state", 64'(state[1]), 64'd1);
    apply_stimulus(1, 32'h204, 32'h0000_0000);
    apply_stimulus(1, 32'h208, 32'h0000_0000);
    check_output("post_done_state", 64'(state[1]), 64'd2);
    apply_stimulus(1, 32'h20C, 32'h0000_0000);
    check_output("post_drop_count", 64'(count[1]), 64'd3);
    check_output("post_drop_state", 64'(state[1]), 64'd2);

    // Back-to-back pops with rd_ready held high.
    exp_pc[0] = 32'h200;
    exp_pc[1] = 32'h204;
    exp_pc[2] = 32'h208;
    rd_ready[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("burst_rd_valid", 64'(rd_valid[1]), 64'd1);
      check_output("burst_rd_pc", 64'(rd_pc[1]), 64'(exp_pc[i]));
      @(negedge clk);
    end
    rd_ready[1] = 1'b0;
    check_output("burst_count", 64'(count[1]), 64'd0);
    check_output("burst_state", 64'(state[1]), 64'd0);
    check_output("burst_rd_valid_end", 64'(rd_valid[1]), 64'd0);

    // clr together with a commit and rd_ready wins over both.
    apply_stimulus(0, 32'h300, 32'h0000_0000);
    check_output("preclr_count", 64'(count[0]), 64'd1);
    clr[0]          = 1'b1;
    rd_ready[0]     = 1'b1;
    commit_valid[0] = 1'b1;
    commit_pc[0]    = 32'h304;
    @(negedge clk);
    clr[0]          = 1'b0;
    rd_ready[0]     = 1'b0;
    commit_valid[0] = 1'b0;
    check_output("clr_count", 64'(count[0]), 64'd0);
    check_output("clr_state", 64'(state[0]), 64'd0);
    check_output("clr_ovw", 64'(ovw_cnt[0]), 64'd0);
    trig_pc[0] = 32'h308;
    apply_stimulus(0, 32'h308, 32'h0085_1021);
    check_output("postclr_count", 64'(count[0]), 64'd1);
    check_output("postclr_rd_pc", 64'(rd_pc[0]), 64'h308);
    check_output("postclr_ascii", 64'(rd_ascii[0]), TXT_ADDU);

    // Asynchronous reset in the middle of a post window.
    trig_pc[1] = 32'h400;
    apply_stimulus(1, 32'h400, 32'h0000_0000);
    check_output("prereset_state", 64'(state[1]), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check_output("areset_state1", 64'(state[1]), 64'd0);
    check_output("areset_count1", 64'(count[1]), 64'd0);
    check_output("areset_state0", 64'(state[0]), 64'd0);
    check_output("areset_rd_valid0", 64'(rd_valid[0]), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(1, 32'h500, 32'h0000_0000);
    check_output("rerun_count", 64'(count[1]), 64'd1);
    check_output("rerun_state", 64'(state[1]), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
